systolic_skew_feeder: RTL
=========================

# systolic_skew_feeder

Upstream operand stage for the `SIZE x SIZE` systolic multiplier array. It buffers one full A matrix, stored by rows, and one full B matrix, stored by columns, through a valid/ready load port. On `start` it streams diagonally skewed operand vectors, one per cycle, onto the array's `A`/`B` lane inputs. Lane `i` is delayed by `i` cycles and unused slots are zero-filled. After the last operand it drives zeros for a fixed drain window so the array's accumulators settle, then pulses `done`.

## Interface
- `SIZE`, 8, matrix dimension and lane count (≥2)
- `DATA_WIDTH`, 16, operand element width
- `clk` in 1, clock
- `rst` in 1, reset, asynchronous, active-low
- `load_valid` in 1, load beat present
- `load_ready` out 1, beat accepted when high with `load_valid`
- `load_sel` in 1, 0 = A row, 1 = B column
- `load_idx` in `$clog2(SIZE)`, row of A or column of B
- `load_data` in `SIZE*DATA_WIDTH`, element k at `[k*DATA_WIDTH +: DATA_WIDTH]` (A[idx][k] or B[k][idx])
- `start` in 1, begin feed run (single-cycle pulse or level)
- `busy` out 1, run in progress
- `a_out` out `SIZE*DATA_WIDTH`, lane i to array `A` lane i
- `b_out` out `SIZE*DATA_WIDTH`, lane j to array `B` lane j
- `feed_valid` out 1, current `a_out`/`b_out` carry a skew step
- `feed_last` out 1, final skew step
- `done` out 1, one-cycle pulse at end of drain

## Operation
- FSM states: IDLE, FEED, DRAIN.
- IDLE: `load_ready`=1. An accepted beat writes the buffer entry selected by `load_sel`/`load_idx`. `load_idx` ≥ SIZE is accepted and discarded.
- IDLE + `start` → FEED, step counter t=0. `start` outside IDLE is ignored.
- FEED, step t (0..2*SIZE-2):
  - a lane i = A[i][t-i] when 0 ≤ t-i < SIZE, else 0.
  - b lane j = B[t-j][j] when 0 ≤ t-j < SIZE, else 0.
- After step 2*SIZE-2 → DRAIN. DRAIN holds `a_out`=`b_out`=0 for SIZE+2 cycles, then → IDLE with `done`=1 for one cycle.
- The buffer is retained across runs. A second run without reload re-feeds the same operands.
- `load_ready`=0 in FEED/DRAIN. Beats offered then are not accepted and have no effect.
- Load and `start` in the same IDLE cycle: the beat is written and used by that run.
- No arithmetic. Data is moved bit-exact and never truncated.

## Timing
- All outputs except `load_ready` and `busy` are registered. `load_ready` = (state==IDLE). `busy` = (state!=IDLE).
- `start` sampled at edge E0. Step t appears on `a_out`/`b_out` after edge E(t+1).
- `feed_valid`=1 for exactly 2*SIZE-1 cycles, starting after E1. `feed_last` is coincident with the final step.
- `done` is asserted after edge E(2*SIZE-1+SIZE+2+1). The next `start` is accepted in that same cycle.
- Reset values: `a_out`=`b_out`=0, `feed_valid`=`feed_last`=`done`=0, `busy`=0, `load_ready`=1, buffers all 0, state IDLE.
- Reset mid-run: immediate return to IDLE, outputs zero, buffers cleared, no `done`.

## Configuration
- `FEEDER_PERF_CNT_EN` defined: adds output `perf_cycles` [31:0], reset 0. It clears on accepted `start`, increments every busy cycle, and holds its value after `done` (saturates at 2^32-1).
- `FEEDER_PERF_CNT_EN` undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- SIZE=2, load A=[[1,2],[3,4]] and B=[[5,6],[7,8]] (B by columns: idx0={5,7}, idx1={6,8}), then start:
  - `a_out` lanes (0,1) = (1,0), (2,3), (0,4).
  - `b_out` lanes = (5,0), (7,6), (0,8).
  - `feed_last` on the 3rd step, then 4 zero cycles, then `done`.
- Start with no loads after reset: 3 all-zero valid steps and `done` at the same cycle as the first test.
- `load_valid` held during FEED: `load_ready`=0, buffer unchanged. A rerun reproduces the first test's sequence.
- `start` pulsed during DRAIN: ignored, single `done`, `busy` falls once.
- `rst` asserted at FEED step 1: outputs 0, `load_ready`=1. A following start without reload yields all-zero steps.
- With `FEEDER_PERF_CNT_EN`, SIZE=2: `perf_cycles`=8 at `done`.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Operand buffer and diagonal-skew feeder for a SIZE x SIZE systolic multiplier array.
// Optional build macro: FEEDER_PERF_CNT_EN adds the perf_cycles busy-cycle counter.
module systolic_skew_feeder #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic                           load_sel,
  input  logic [$clog2(SIZE)-1:0]        load_idx,
  input  logic [SIZE*DATA_WIDTH-1:0]     load_data,
  input  logic                           start,
  output logic                           busy,
  output logic [SIZE*DATA_WIDTH-1:0]     a_out,
  output logic [SIZE*DATA_WIDTH-1:0]     b_out,
  output logic                           feed_valid,
  output logic                           feed_last,
`ifdef FEEDER_PERF_CNT_EN
  output logic [31:0]                    perf_cycles,
`endif
  output logic                           done
);

  localparam int unsigned IDX_W      = $clog2(SIZE);
  localparam int unsigned VEC_W      = SIZE * DATA_WIDTH;
  localparam int unsigned FEED_STEPS = 2 * SIZE - 1;
  localparam int unsigned DRAIN_LEN  = SIZE + 2;
  localparam int unsigned CNT_W      = $clog2(2 * SIZE + DRAIN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [VEC_W-1:0]        a_nxt, b_nxt;
  logic                    valid_nxt, last_nxt, done_nxt;
  logic                    load_acc;

  // a_mem[row][k] = A[row][k]; b_mem[col][k] = B[k][col]
  logic [DATA_WIDTH-1:0]   a_mem [SIZE][SIZE];
  logic [DATA_WIDTH-1:0]   b_mem [SIZE][SIZE];

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign load_acc   = load_valid && (state == IDLE);

  // State and step/drain counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = '0;
    b_nxt     = '0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FEED;
          cnt_nxt   = '0;
        end
      end
      FEED: begin
        valid_nxt = 1'b1;
        // Lane i carries element (cnt - i) of its row/column, zero outside the window
        for (int i = 0; i < SIZE; i++) begin
          for (int k = 0; k < SIZE; k++) begin
            if (cnt == CNT_W'(i + k)) begin
              a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = a_mem[i][k];
              b_nxt[i*DATA_WIDTH +: DATA_WIDTH] = b_mem[i][k];
            end
          end
        end
        if (cnt == CNT_W'(FEED_STEPS - 1)) begin
          last_nxt  = 1'b1;
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        // The edge that leaves DRAIN is the one that raises done
        if (cnt == CNT_W'(DRAIN_LEN)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered array-facing outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out      <= '0;
      b_out      <= '0;
      feed_valid <= 1'b0;
      feed_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      a_out      <= a_nxt;
      b_out      <= b_nxt;
      feed_valid <= valid_nxt;
      feed_last  <= last_nxt;
      done       <= done_nxt;
    end
  end

  // Operand buffers; an index with no matching row/column is simply dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          a_mem[r][k] <= '0;
          b_mem[r][k] <= '0;
        end
      end
    end else if (load_acc) begin
      for (int r = 0; r < SIZE; r++) begin
        if (load_idx == IDX_W'(r)) begin
          for (int k = 0; k < SIZE; k++) begin
            if (!load_sel) a_mem[r][k] <= load_data[k*DATA_WIDTH +: DATA_WIDTH];
            else           b_mem[r][k] <= load_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  // Busy-cycle counter, cleared by an accepted start, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= '0;
    end else if ((state != IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
